// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: issues one data-memory access per request over a
// req/ready + rvalid handshake, aligning store lanes and extending load results.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 16
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        Start,
  input  logic        IsWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ReadData,
  output logic [1:0]  Fault,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemWStrb,
  input  logic        MemReady,
  input  logic [31:0] MemRData,
  input  logic        MemRValid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t               state_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 we_q;
  logic [2:0]           f3_q;
  logic [1:0]           off_q;
  logic [31:0]          rdata_q;
  logic [31:0]          maddr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           strb_q;
  logic [1:0]           fault_q;

  logic        illegal;
  logic        misaligned;
  logic [3:0]  strb_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_d;
  logic        cnt_last;

  always_comb begin
    illegal    = (Funct3 == 3'b011) || (Funct3[2:1] == 2'b11) || (Funct3[2] && IsWrite);
    misaligned = ((Funct3[1:0] == 2'b01) && Addr[0]) ||
                 ((Funct3[1:0] == 2'b10) && (Addr[1:0] != 2'b00));
    case (Funct3[1:0])
      2'b00: begin
        strb_d  = 4'b0001 << Addr[1:0];
        wdata_d = {4{WriteData[7:0]}};
      end
      2'b01: begin
        strb_d  = 4'b0011 << Addr[1:0];
        wdata_d = {2{WriteData[15:0]}};
      end
      default: begin
        strb_d  = 4'b1111;
        wdata_d = WriteData;
      end
    endcase
  end

  // Lane selection uses the offset latched at Start, not the live address.
  always_comb begin
    byte_sel = MemRData[{off_q, 3'b000} +: 8];
    half_sel = off_q[1] ? MemRData[31:16] : MemRData[15:0];
    case (f3_q)
      3'b000:  load_d = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_d = {24'h000000, byte_sel};
      3'b001:  load_d = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_d = {16'h0000, half_sel};
      default: load_d = MemRData;
    endcase
  end

  assign cnt_last = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= 2'b00;
      rdata_q <= 32'h0;
      maddr_q <= 32'h0;
      wdata_q <= 32'h0;
      strb_q  <= 4'h0;
      fault_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (Start) begin
            we_q    <= IsWrite;
            f3_q    <= Funct3;
            off_q   <= Addr[1:0];
            maddr_q <= {Addr[31:2], 2'b00};
            wdata_q <= wdata_d;
            strb_q  <= IsWrite ? strb_d : 4'h0;
            rdata_q <= 32'h0;
            cnt_q   <= '0;
            if (illegal) begin
              fault_q <= 2'b11;
              state_q <= RESP;
            end else if (misaligned) begin
              fault_q <= 2'b01;
              state_q <= RESP;
            end else begin
              fault_q <= 2'b00;
              state_q <= REQ;
            end
          end
        end
        REQ: begin
          cnt_q <= cnt_q + CNT_WIDTH'(1);
          if (MemReady) begin
            state_q <= we_q ? RESP : WAIT;
          end else if (cnt_last) begin
            fault_q <= 2'b10;
            state_q <= RESP;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q + CNT_WIDTH'(1);
          // Data arriving on the final budgeted cycle still wins over the timeout.
          if (MemRValid) begin
            rdata_q <= load_d;
            state_q <= RESP;
          end else if (cnt_last) begin
            fault_q <= 2'b10;
            state_q <= RESP;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Busy     = (state_q != IDLE);
  assign Done     = (state_q == RESP);
  assign MemReq   = (state_q == REQ);
  assign MemWE    = MemReq && we_q;
  assign MemAddr  = maddr_q;
  assign MemWData = wdata_q;
  assign MemWStrb = strb_q;
  assign ReadData = rdata_q;
  assign Fault    = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-in-flight sequence and
// randomized transactions against a transaction-level memory model.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic        IsWrite = 1'b0;
  logic [2:0]  Funct3 = 3'b000;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic        Busy, Done, MemReq, MemWE;
  logic [31:0] ReadData, MemAddr, MemWData;
  logic [1:0]  Fault;
  logic [3:0]  MemWStrb;
  logic        MemReady = 1'b0;
  logic [31:0] MemRData = 32'h0;
  logic        MemRValid = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  load_store_unit #(.TIMEOUT_CYCLES(TMO), .CNT_WIDTH(16)) dut (
    .CLK(CLK), .Reset(Reset), .Start(Start), .IsWrite(IsWrite), .Funct3(Funct3),
    .Addr(Addr), .WriteData(WriteData), .Busy(Busy), .Done(Done), .ReadData(ReadData),
    .Fault(Fault), .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemWStrb(MemWStrb), .MemReady(MemReady),
    .MemRData(MemRData), .MemRValid(MemRValid)
  );

  always #5 CLK = ~CLK;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endfunction

  // Transaction-level expectation: fault class, latency from the cycle budget, lane data.
  function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] rd, input int rdy,
                                input int rv, output logic [1:0] fault, output logic [31:0] rdata,
                                output int lat, output int reqc, output logic [3:0] strb,
                                output logic [31:0] wdata);
    int nbytes, off, need;
    longint b, h;
    nbytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off    = int'(addr % 4);
    strb   = wr ? 4'(((1 << nbytes) - 1) << off) : 4'h0;
    case (nbytes)
      1:       wdata = (wd & 32'hFF) * 32'h01010101;
      2:       wdata = (wd & 32'hFFFF) * 32'h00010001;
      default: wdata = wd;
    endcase
    fault = 2'd0; rdata = 32'h0; lat = 1; reqc = 0;
    if (f3 == 3 || f3 == 6 || f3 == 7 || (wr && f3 >= 4)) begin
      fault = 2'd3;
    end else if ((off % nbytes) != 0) begin
      fault = 2'd1;
    end else begin
      need = wr ? rdy + 1 : rdy + rv + 2;
      if (need <= TMO) begin
        lat  = 1 + need;
        reqc = rdy + 1;
        if (!wr) begin
          b = longint'((rd >> (8 * off)) & 32'hFF);
          h = longint'((rd >> (16 * (off / 2))) & 32'hFFFF);
          case (f3)
            3'd0:    rdata = 32'(b >= 128 ? b - 256 : b);
            3'd4:    rdata = 32'(b);
            3'd1:    rdata = 32'(h >= 32768 ? h - 65536 : h);
            3'd5:    rdata = 32'(h);
            default: rdata = rd;
          endcase
        end
      end else begin
        lat   = 1 + TMO;
        fault = 2'd2;
        reqc  = (rdy + 1 < TMO) ? rdy + 1 : TMO;
      end
    end
  endfunction

  // Runs one transaction starting at a negedge, acting as the memory; returns at a negedge.
  task automatic do_txn(input int id, input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int rdy, input int rv,
                        input bit poke, input bit post, input logic [1:0] efault,
                        input logic [31:0] erd, input int elat, input int ereq,
                        input logic [3:0] estrb, input logic [31:0] ewd);
    int cyc, reqc, wcnt, lat;
    bit acc, acc_now, done_seen;
    logic [1:0] ofault;
    logic [31:0] ord;
    Start = 1'b1; IsWrite = wr; Funct3 = f3; Addr = addr; WriteData = wd;
    MemReady = 1'b0; MemRValid = 1'b0;
    @(negedge CLK);
    Start = 1'b0; IsWrite = ~wr; Addr = $urandom; WriteData = $urandom;
    Funct3 = 3'($urandom_range(0, 7));
    cyc = 1; reqc = 0; wcnt = 0; acc = 0; done_seen = 0; lat = 0;
    ofault = 2'b00; ord = 32'h0;
    while (!done_seen && cyc <= 40) begin
      MemReady = 1'b0; MemRValid = 1'b0; MemRData = $urandom; acc_now = 0;
      if (Done) begin
        done_seen = 1; lat = cyc; ofault = Fault; ord = ReadData;
      end else begin
        chk("busy_inflight", 32'(Busy), 32'd1);
        if (MemReq) begin
          chk("mem_addr", MemAddr, addr & 32'hFFFF_FFFC);
          chk("mem_we", 32'(MemWE), 32'(wr));
          chk("mem_strb", 32'(MemWStrb), 32'(estrb));
          if (wr) chk("mem_wdata", MemWData, ewd);
          MemReady = (reqc >= rdy);
          acc_now = MemReady;
          reqc++;
        end else if (acc) begin
          MemRValid = (wcnt == rv);
          if (MemRValid) MemRData = rd;
          wcnt++;
        end
        if (poke && cyc == 2) begin
          Start = 1'b1; IsWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h80;
        end
        @(negedge CLK);
        Start = 1'b0;
        if (acc_now) acc = 1;
        cyc++;
      end
    end
    MemReady = 1'b0; MemRValid = 1'b0;
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("latency", 32'(lat), 32'(elat));
    chk("fault", 32'(ofault), 32'(efault));
    chk("read_data", ord, erd);
    chk("req_cycles", 32'(reqc), 32'(ereq));
    @(negedge CLK);
    chk("done_pulse", 32'(Done), 32'd0);
    chk("busy_fall", 32'(Busy), 32'd0);
    if (post) begin
      MemRValid = 1'b1; MemRData = $urandom;
      @(negedge CLK);
      MemRValid = 1'b0;
      chk("stray_rvalid_done", 32'(Done), 32'd0);
      chk("stray_rvalid_busy", 32'(Busy), 32'd0);
    end
    $display("txn %0d wr=%0b f3=%0d addr=%08h fault=%0d rdata=%08h lat=%0d req=%0d",
             id, wr, f3, addr, ofault, ord, lat, reqc);
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          rdy;
    int          rv;
    bit          poke;
    bit          post;
    logic [1:0]  efault;
    logic [31:0] erd;
    int          elat;
    int          ereq;
    logic [3:0]  estrb;
    logic [31:0] ewd;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic        r_wr;
    logic [2:0]  r_f3;
    logic [31:0] r_addr, r_wd, r_rd, m_rd, m_wd;
    int          r_rdy, r_rv, m_lat, m_req;
    logic [1:0]  m_fault;
    logic [3:0]  m_strb;

    tbl[0]  = '{1'b1, 3'b000, 32'h1003, 32'h000000A5, 32'h0, 0, 0, 1'b0, 1'b1, 2'd0, 32'h0, 2, 1, 4'b1000, 32'hA5A5A5A5};
    tbl[1]  = '{1'b0, 3'b000, 32'h2002, 32'h0, 32'h12F45678, 0, 0, 1'b0, 1'b1, 2'd0, 32'hFFFFFFF4, 3, 1, 4'h0, 32'h0};
    tbl[2]  = '{1'b0, 3'b100, 32'h2002, 32'h0, 32'h12F45678, 0, 0, 1'b0, 1'b0, 2'd0, 32'h000000F4, 3, 1, 4'h0, 32'h0};
    tbl[3]  = '{1'b0, 3'b101, 32'h2002, 32'h0, 32'h12F45678, 0, 0, 1'b0, 1'b0, 2'd0, 32'h000012F4, 3, 1, 4'h0, 32'h0};
    tbl[4]  = '{1'b0, 3'b010, 32'h3001, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 2'd1, 32'h0, 1, 0, 4'h0, 32'h0};
    tbl[5]  = '{1'b0, 3'b110, 32'h3000, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 2'd3, 32'h0, 1, 0, 4'h0, 32'h0};
    tbl[6]  = '{1'b1, 3'b010, 32'h0010, 32'hDEADBEEF, 32'h0, 0, 0, 1'b0, 1'b0, 2'd0, 32'h0, 2, 1, 4'hF, 32'hDEADBEEF};
    tbl[7]  = '{1'b0, 3'b001, 32'h0010, 32'h0, 32'h8001ABCD, 0, 0, 1'b0, 1'b0, 2'd0, 32'hFFFFABCD, 3, 1, 4'h0, 32'h0};
    tbl[8]  = '{1'b0, 3'b010, 32'h0040, 32'h0, 32'h0, 10, 0, 1'b1, 1'b1, 2'd2, 32'h0, 5, 4, 4'h0, 32'h0};
    tbl[9]  = '{1'b1, 3'b001, 32'h0022, 32'h00001234, 32'h0, 0, 0, 1'b0, 1'b0, 2'd0, 32'h0, 2, 1, 4'b1100, 32'h12341234};
    tbl[10] = '{1'b1, 3'b100, 32'h0020, 32'h55, 32'h0, 0, 0, 1'b0, 1'b0, 2'd3, 32'h0, 1, 0, 4'h0, 32'h0};
    tbl[11] = '{1'b0, 3'b010, 32'h0044, 32'h0, 32'h11112222, 1, 2, 1'b0, 1'b1, 2'd2, 32'h0, 5, 2, 4'h0, 32'h0};
    tbl[12] = '{1'b0, 3'b001, 32'h0101, 32'h0, 32'h0, 0, 0, 1'b0, 1'b0, 2'd1, 32'h0, 1, 0, 4'h0, 32'h0};
    tbl[13] = '{1'b0, 3'b010, 32'h0048, 32'h0, 32'hCAFEF00D, 1, 1, 1'b0, 1'b0, 2'd0, 32'hCAFEF00D, 5, 2, 4'h0, 32'h0};

    repeat (3) @(negedge CLK);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_memreq", 32'(MemReq), 32'd0);
    chk("rst_memwe", 32'(MemWE), 32'd0);
    chk("rst_readdata", ReadData, 32'h0);
    chk("rst_memaddr", MemAddr, 32'h0);
    chk("rst_memwdata", MemWData, 32'h0);
    chk("rst_memwstrb", 32'(MemWStrb), 32'h0);
    chk("rst_fault", 32'(Fault), 32'h0);
    Reset = 1'b0;
    @(negedge CLK);

    // Reset while a load waits for data; a late rvalid must not produce Done.
    Start = 1'b1; IsWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h200;
    @(negedge CLK);
    Start = 1'b0;
    chk("rstmid_req", 32'(MemReq), 32'd1);
    MemReady = 1'b1;
    @(negedge CLK);
    MemReady = 1'b0;
    chk("rstmid_wait_busy", 32'(Busy), 32'd1);
    chk("rstmid_wait_req", 32'(MemReq), 32'd0);
    Reset = 1'b1;
    @(negedge CLK);
    chk("rstmid_busy", 32'(Busy), 32'd0);
    chk("rstmid_memreq", 32'(MemReq), 32'd0);
    chk("rstmid_done", 32'(Done), 32'd0);
    Reset = 1'b0;
    MemRValid = 1'b1; MemRData = 32'h76543210;
    @(negedge CLK);
    MemRValid = 1'b0;
    chk("rstmid_late_done", 32'(Done), 32'd0);
    @(negedge CLK);
    chk("rstmid_late_done2", 32'(Done), 32'd0);
    chk("rstmid_late_busy", 32'(Busy), 32'd0);
    $display("txn reset-mid-load done");

    for (int i = 0; i < 14; i++) begin
      do_txn(i, tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].rd, tbl[i].rdy, tbl[i].rv,
             tbl[i].poke, tbl[i].post, tbl[i].efault, tbl[i].erd, tbl[i].elat, tbl[i].ereq,
             tbl[i].estrb, tbl[i].ewd);
    end

    for (int i = 0; i < 150; i++) begin
      r_wr   = 1'($urandom_range(0, 1));
      r_f3   = 3'($urandom_range(0, 7));
      r_addr = $urandom;
      r_wd   = $urandom;
      r_rd   = $urandom;
      r_rdy  = int'($urandom_range(0, 2));
      r_rv   = int'($urandom_range(0, 1));
      model(r_wr, r_f3, r_addr, r_wd, r_rd, r_rdy, r_rv, m_fault, m_rd, m_lat, m_req, m_strb, m_wd);
      do_txn(100 + i, r_wr, r_f3, r_addr, r_wd, r_rd, r_rdy, r_rv,
             ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
             m_fault, m_rd, m_lat, m_req, m_strb, m_wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage block directly downstream of the ALU.
- Takes the ALU-computed effective address (ALUResult of load/store ops) plus store data (Src2) and funct3, and runs one data-memory transaction over a req/ready + rvalid handshake.
- Aligns store bytes and byte strobes; extracts and sign/zero-extends load data.
- Returns a one-cycle Done pulse with ReadData and a fault code to the writeback/hazard logic, and holds Busy to stall the pipeline meanwhile.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+WAIT before the access aborts with a timeout fault; legal range 1..65535.
- CNT_WIDTH, 16: width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous reset, active-high.
- Start  in  1  one-cycle request from the EX stage; accepted only in IDLE.
- IsWrite  in  1  1 = store (SB/SH/SW), 0 = load.
- Funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- Addr  in  32  effective address from the ALU.
- WriteData  in  32  store source (rs2 value).
- Busy  out  1  high in every state except IDLE.
- Done  out  1  one-cycle completion pulse.
- ReadData  out  32  extended load result; valid while Done=1.
- Fault  out  2  valid while Done=1: 00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.
- MemReq  out  1  memory request valid.
- MemWE  out  1  write enable, qualified by MemReq.
- MemAddr  out  32  word address, {Addr[31:2],2'b00}.
- MemWData  out  32  lane-replicated store data.
- MemWStrb  out  4  byte strobes; 0000 for reads.
- MemReady  in  1  memory accepts the request this cycle when MemReq=1.
- MemRData  in  32  read word.
- MemRValid  in  1  read data valid; one cycle.

Behaviour:
- Reset: state IDLE, counter 0. Busy, Done, MemReq and MemWE are 0. ReadData, MemAddr, MemWData, MemWStrb and Fault are 0. Reset overrides everything, including mid-transaction; MemReq is low the cycle after Reset is sampled.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, Start=1:
  - Latch IsWrite, Funct3, Addr and WriteData.
  - If Funct3 is illegal (011, 110, 111, or 1xx with IsWrite=1): go to RESP with Fault=11.
  - Else if misaligned (H/HU with Addr[0]=1, or W with Addr[1:0]!=00): go to RESP with Fault=01.
  - In both fault cases no MemReq is issued.
  - Otherwise go to REQ.
- Start while Busy=1 is ignored (no queueing).
- REQ:
  - MemReq=1; MemAddr, MemWE, MemWData and MemWStrb are held stable until accepted.
  - On MemReady=1, a store goes to RESP and a load goes to WAIT.
- WAIT:
  - MemReq=0.
  - On MemRValid=1, extract load data and go to RESP.
  - MemRValid in the same cycle as acceptance is not used; data arrives at earliest the cycle after.
- Timeout:
  - The counter clears on entry to REQ and increments every cycle in REQ or WAIT.
  - When the counter reaches TIMEOUT_CYCLES without completion, go to RESP with Fault=10, ReadData=0 and MemReq dropped.
  - Late MemRValid arriving after a timeout is ignored.
- RESP: Done=1 for exactly one cycle, then IDLE. Busy falls the cycle after Done.
- Minimum latency from Start to Done:
  - Store, with MemReady already high: 2 cycles.
  - Load, with MemReady high and MemRValid the next cycle: 3 cycles.
  - Faulted access: 1 cycle.
- Store alignment, with o = Addr[1:0]:
  - SB: MemWData = {4{WriteData[7:0]}}, MemWStrb = 0001<<o.
  - SH: MemWData = {2{WriteData[15:0]}}, MemWStrb = 0011<<o.
  - SW: MemWData = WriteData, MemWStrb = 1111.
- Load extraction:
  - Byte = MemRData[8*o+7 : 8*o].
  - Half = MemRData[16*o[1]+15 : 16*o[1]].
  - LB and LH sign-extend; LBU and LHU zero-extend; LW passes through.
- ReadData is 0 for stores and for every faulted access.

Test Plan:
- Reset mid-load, asserted in WAIT → next cycle: IDLE, Busy=0, MemReq=0; a subsequent MemRValid produces no Done.
- SB, Addr=0x1003, WriteData=0x000000A5, MemReady=1 → MemAddr=0x1000, MemWStrb=1000, MemWData=0xA5A5A5A5, MemWE=1; Done two cycles after Start with Fault=00.
- LB, Addr=0x2002, MemRData=0x12F45678 delivered one cycle after accept → ReadData=0xFFFFFFF4. LBU at the same address → 0x000000F4. LHU at 0x2002 → 0x000012F4.
- LW, Addr=0x3001 → Done the cycle after Start, Fault=01, MemReq never asserted. Funct3=110 → Fault=11.
- TIMEOUT_CYCLES=4, load with MemReady held 0 → MemReq high for 4 cycles, then Done with Fault=10 and ReadData=0; Start during Busy is ignored.
- Back-to-back SW then LH (Addr=0x10, MemRData=0x8001ABCD) → second Start accepted the cycle after the first Done; LH ReadData=0xFFFFABCD.
